// File: rtl/mmio_data_bus.sv
// rtl/mmio_data_bus.sv - data-side bus decode onto RAM, timer, LED/digits, systick and UART TX
module mmio_data_bus #(
    parameter int RAM_AW       = 10,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_mem_write,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [7:0]        led,
    output logic [15:0]       digits,
    output logic              timer_irq,
    output logic              uart_txd
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    logic        periph_sel, map_hit, periph_wr;
    logic [5:0]  offset;
    logic        wr_th, wr_tl, wr_tcon, wr_led, wr_digits, wr_utx, wr_ucon;
    logic [31:0] th, tl, systick;
    logic        t_run, t_ien, t_status;
    logic        unused_addr_lsbs;

    // Only 0x4000_00xx is mapped; the rest of the peripheral space reads as a hole.
    assign periph_sel = (cpu_addr[31:28] == 4'h4);
    assign map_hit    = periph_sel && (cpu_addr[27:8] == 20'd0);
    assign offset     = cpu_addr[7:2];
    assign periph_wr  = cpu_mem_write && map_hit;
    assign wr_th      = periph_wr && (offset == 6'h00);
    assign wr_tl      = periph_wr && (offset == 6'h01);
    assign wr_tcon    = periph_wr && (offset == 6'h02);
    assign wr_led     = periph_wr && (offset == 6'h03);
    assign wr_digits  = periph_wr && (offset == 6'h04);
    assign wr_utx     = periph_wr && (offset == 6'h06);
    assign wr_ucon    = periph_wr && (offset == 6'h07);
    assign unused_addr_lsbs = ^cpu_addr[1:0];

    assign ram_we    = cpu_mem_write && !periph_sel;
    assign ram_addr  = cpu_addr[RAM_AW+1:2];
    assign ram_wdata = cpu_wdata;
    assign timer_irq = t_status;

    // Software writes to TL/TCON take priority over the hardware reload and status set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th <= '0; tl <= '0; t_run <= 1'b0; t_ien <= 1'b0; t_status <= 1'b0;
            led <= '0; digits <= '0; systick <= '0;
        end else begin
            systick <= systick + 32'd1;
            if (wr_th)     th     <= cpu_wdata;
            if (wr_led)    led    <= cpu_wdata[7:0];
            if (wr_digits) digits <= cpu_wdata[15:0];
            if (wr_tl)
                tl <= cpu_wdata;
            else if (t_run)
                tl <= (&tl) ? th : tl + 32'd1;
            if (wr_tcon)
                {t_status, t_ien, t_run} <= cpu_wdata[2:0];
            else if (t_run && (&tl) && t_ien)
                t_status <= 1'b1;
        end
    end

    logic [7:0]        fifo_mem [4];
    logic [1:0]        wr_ptr, rd_ptr;
    logic [2:0]        count;
    logic              fifo_full, fifo_empty, push, pop, overflow;
    uart_state_t       state, next_state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        tx_byte;
    logic              baud_done, uart_busy;

    assign fifo_full  = (count == 3'd4);
    assign fifo_empty = (count == 3'd0);
    assign push       = wr_utx && !fifo_full;
    assign pop        = (state == S_IDLE) && !fifo_empty;
    assign baud_done  = (baud_cnt == BAUD_LAST);

    // A dropped push still flags overflow even if a clear lands in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0; overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: ;
            endcase
            if (wr_utx && fifo_full)
                overflow <= 1'b1;
            else if (wr_ucon && cpu_wdata[3])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= cpu_wdata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_byte <= '0; baud_cnt <= '0; bit_cnt <= '0;
        end else if (pop) begin
            tx_byte <= fifo_mem[rd_ptr]; baud_cnt <= '0; bit_cnt <= '0;
        end else if (state != S_IDLE) begin
            if (baud_done) begin
                baud_cnt <= '0;
                if (state == S_DATA) bit_cnt <= bit_cnt + 3'd1;
            end else begin
                baud_cnt <= baud_cnt + BAUD_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (!fifo_empty) next_state = S_START;
            S_START: if (baud_done) next_state = S_DATA;
            S_DATA:  if (baud_done && bit_cnt == 3'd7) next_state = S_STOP;
            S_STOP:  if (baud_done) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        uart_txd  = 1'b1;
        uart_busy = 1'b1;
        case (state)
            S_IDLE:  uart_busy = 1'b0;
            S_START: uart_txd  = 1'b0;
            S_DATA:  uart_txd  = tx_byte[bit_cnt];
            default: uart_txd  = 1'b1;
        endcase
    end

    always_comb begin
        cpu_rdata = 32'd0;
        if (!periph_sel) begin
            cpu_rdata = ram_rdata;
        end else if (map_hit) begin
            case (offset)
                6'h00:   cpu_rdata = th;
                6'h01:   cpu_rdata = tl;
                6'h02:   cpu_rdata = {29'd0, t_status, t_ien, t_run};
                6'h03:   cpu_rdata = {24'd0, led};
                6'h04:   cpu_rdata = {16'd0, digits};
                6'h05:   cpu_rdata = systick;
                6'h07:   cpu_rdata = {28'd0, overflow, uart_busy, fifo_empty, fifo_full};
                default: cpu_rdata = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_data_bus.sv
// tb/tb_mmio_data_bus.sv - directed self-checking bench for mmio_data_bus
module tb_mmio_data_bus;
    localparam int CPB = 4;
    localparam logic [31:0] A_TH = 32'h4000_0000, A_TL = 32'h4000_0004, A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED = 32'h4000_000C, A_DIG = 32'h4000_0010, A_TICK = 32'h4000_0014;
    localparam logic [31:0] A_UTX = 32'h4000_0018, A_UCON = 32'h4000_001C;

    logic        clk, reset, cpu_mem_write;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;
    logic        ram_we, timer_irq, uart_txd;
    logic [9:0]  ram_addr;
    logic [7:0]  led;
    logic [15:0] digits;
    logic [31:0] ram_mem [1024];
    logic [7:0]  rx_q [$];
    int tests_run = 0;
    int tests_failed = 0;

    mmio_data_bus #(.RAM_AW(10), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .cpu_mem_write(cpu_mem_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .led(led), .digits(digits),
        .timer_irq(timer_irq), .uart_txd(uart_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    assign ram_rdata = ram_mem[ram_addr];

    // All tasks start and end just after a falling edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cpu_addr = a; cpu_wdata = d; cpu_mem_write = 1'b1;
        @(negedge clk);
        cpu_mem_write = 1'b0;
    endtask

    task automatic collect_frames(input int max_idle, output int nframes);
        int idle;
        logic [7:0] b;
        nframes = 0; idle = 0;
        while (idle < max_idle) begin
            @(negedge clk);
            if (uart_txd === 1'b0) begin
                repeat (CPB + CPB / 2) @(negedge clk);
                b[0] = uart_txd;
                for (int i = 1; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_txd;
                end
                repeat (CPB) @(negedge clk);
                tests_run++;
                if (uart_txd !== 1'b1) begin
                    tests_failed++; $display("FAIL stop_bit: got %b expected 1", uart_txd);
                end
                rx_q.push_back(b);
                nframes++; idle = 0;
            end else begin
                idle++;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; cpu_mem_write = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({led, digits, timer_irq, uart_txd} !== {8'h00, 16'h0000, 1'b0, 1'b1}) begin
            tests_failed++; $display("FAIL reset_outputs: got %h/%h/%b/%b expected 00/0000/0/1", led, digits, timer_irq, uart_txd);
        end
        cpu_addr = A_UCON; #1;
        tests_run++;
        if (cpu_rdata !== 32'h2) begin
            tests_failed++; $display("FAIL reset_ucon: got %h expected 00000002", cpu_rdata);
        end
        @(negedge clk);
        reset = 1'b0; cpu_addr = A_TICK; #1;
        tests_run++;
        if (cpu_rdata !== 32'd0) begin
            tests_failed++; $display("FAIL systick_start: got %h expected 0", cpu_rdata);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (cpu_rdata !== 32'd3) begin
            tests_failed++; $display("FAIL systick_count: got %h expected 3", cpu_rdata);
        end
    endtask

    task automatic test_ram;
        cpu_addr = 32'h1001_0008; cpu_wdata = 32'hDEAD_BEEF; cpu_mem_write = 1'b1; #1;
        tests_run++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 10'd2, 32'hDEAD_BEEF}) begin
            tests_failed++; $display("FAIL ram_store: got we=%b addr=%0d wdata=%h expected 1/2/deadbeef", ram_we, ram_addr, ram_wdata);
        end
        @(negedge clk);
        cpu_mem_write = 1'b0; #1;
        tests_run++;
        if (cpu_rdata !== 32'hDEAD_BEEF) begin
            tests_failed++; $display("FAIL ram_load: got %h expected deadbeef", cpu_rdata);
        end
        cpu_addr = 32'h4000_0030; #1;
        tests_run++;
        if (cpu_rdata !== 32'd0) begin
            tests_failed++; $display("FAIL unmapped_read: got %h expected 0", cpu_rdata);
        end
        cpu_addr = A_LED; cpu_wdata = 32'h0000_01A5; cpu_mem_write = 1'b1; #1;
        tests_run++;
        if ({ram_we, cpu_rdata} !== {1'b0, 32'h0}) begin
            tests_failed++; $display("FAIL periph_write_old: got we=%b rdata=%h expected 0/0", ram_we, cpu_rdata);
        end
        @(negedge clk);
        cpu_mem_write = 1'b0;
    endtask

    task automatic test_led_digits;
        wr(A_DIG, 32'h1234_5678);
        wr(32'h4000_0020, 32'hFFFF_FFFF);
        wr(A_TICK, 32'h0);
        tests_run++;
        if ({led, digits} !== {8'hA5, 16'h5678}) begin
            tests_failed++; $display("FAIL led_digits: got %h/%h expected a5/5678", led, digits);
        end
        cpu_addr = A_DIG; #1;
        tests_run++;
        if (cpu_rdata !== 32'h0000_5678) begin
            tests_failed++; $display("FAIL digits_read: got %h expected 00005678", cpu_rdata);
        end
        cpu_addr = A_TICK; #1;
        tests_run++;
        if (cpu_rdata < 32'd8) begin
            tests_failed++; $display("FAIL systick_ro: got %h expected >= 8", cpu_rdata);
        end
    endtask

    task automatic test_timer;
        logic [31:0] exp_tl [4];
        logic        exp_irq [4];
        exp_tl = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFF1};
        exp_irq = '{1'b0, 1'b0, 1'b1, 1'b1};
        wr(A_TH, 32'hFFFF_FFF0);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'h3);
        cpu_addr = A_TL;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            tests_run++;
            if ({cpu_rdata, timer_irq} !== {exp_tl[i], exp_irq[i]}) begin
                tests_failed++; $display("FAIL timer_step%0d: got tl=%h irq=%b expected %h/%b", i, cpu_rdata, timer_irq, exp_tl[i], exp_irq[i]);
            end
        end
        wr(A_TCON, 32'h3);
        cpu_addr = A_TCON; #1;
        tests_run++;
        if ({timer_irq, cpu_rdata} !== {1'b0, 32'h3}) begin
            tests_failed++; $display("FAIL timer_clear: got irq=%b tcon=%h expected 0/3", timer_irq, cpu_rdata);
        end
        wr(A_TCON, 32'h0);
    endtask

    task automatic test_uart_frame;
        logic [7:0] d;
        logic       exp;
        int         bitn;
        d = 8'h55;
        wr(A_UTX, {24'h0, d});
        cpu_addr = A_UCON; #1;
        tests_run++;
        if ({uart_txd, cpu_rdata} !== {1'b1, 32'h0}) begin
            tests_failed++; $display("FAIL uart_push: got txd=%b ucon=%h expected 1/0", uart_txd, cpu_rdata);
        end
        for (int k = 0; k < 10 * CPB; k++) begin
            @(negedge clk); #1;
            bitn = k / CPB;
            exp = (bitn == 0) ? 1'b0 : (bitn == 9) ? 1'b1 : d[bitn-1];
            tests_run++;
            if ({uart_txd, cpu_rdata} !== {exp, 32'h6}) begin
                tests_failed++; $display("FAIL uart_cycle%0d: got txd=%b ucon=%h expected %b/00000006", k, uart_txd, cpu_rdata, exp);
            end
        end
        @(negedge clk); #1;
        tests_run++;
        if ({uart_txd, cpu_rdata} !== {1'b1, 32'h2}) begin
            tests_failed++; $display("FAIL uart_idle: got txd=%b ucon=%h expected 1/00000002", uart_txd, cpu_rdata);
        end
    endtask

    task automatic test_back_to_back;
        int nframes;
        logic [31:0] exp_ucon;
        logic [7:0] exp_b [5];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        rx_q.delete();
        fork
            collect_frames(20, nframes);
            begin
                wr(A_UTX, 32'h11);
                @(negedge clk);
                for (int i = 1; i <= 6; i++) begin
                    wr(A_UTX, 32'h11 * (i + 1));
                    cpu_addr = A_UCON; #1;
                    exp_ucon = {28'd0, (i >= 5), 1'b1, 1'b0, (i >= 4)};
                    tests_run++;
                    if (cpu_rdata !== exp_ucon) begin
                        tests_failed++; $display("FAIL fifo_after_push%0d: got %h expected %h", i, cpu_rdata, exp_ucon);
                    end
                end
            end
        join
        tests_run++;
        if (nframes !== 5) begin
            tests_failed++; $display("FAIL frame_count: got %0d expected 5", nframes);
        end
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            tests_run++;
            if (rx_q[i] !== exp_b[i]) begin
                tests_failed++; $display("FAIL rx_byte%0d: got %h expected %h", i, rx_q[i], exp_b[i]);
            end
        end
        wr(A_UCON, 32'h8);
        cpu_addr = A_UCON; #1;
        tests_run++;
        if (cpu_rdata !== 32'h2) begin
            tests_failed++; $display("FAIL overflow_clear: got %h expected 00000002", cpu_rdata);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] addrs [7];
        int nframes;
        addrs = '{A_TH, A_TL, A_TCON, A_LED, A_DIG, A_TICK, A_UTX};
        wr(A_TH, 32'h1234); wr(A_TCON, 32'h7); wr(A_LED, 32'h3C);
        wr(A_UTX, 32'hA5); wr(A_UTX, 32'h3C); wr(A_UTX, 32'h0F);
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({uart_txd, led, digits, timer_irq} !== {1'b1, 8'h0, 16'h0, 1'b0}) begin
            tests_failed++; $display("FAIL async_reset_out: got txd=%b led=%h dig=%h irq=%b expected 1/00/0000/0", uart_txd, led, digits, timer_irq);
        end
        cpu_addr = A_UCON; #1;
        tests_run++;
        if (cpu_rdata !== 32'h2) begin
            tests_failed++; $display("FAIL reset_ucon_mid: got %h expected 00000002", cpu_rdata);
        end
        for (int i = 0; i < 7; i++) begin
            cpu_addr = addrs[i]; #1;
            tests_run++;
            if (cpu_rdata !== 32'h0) begin
                tests_failed++; $display("FAIL reset_reg%0d: got %h expected 0", i, cpu_rdata);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        cpu_addr = A_TICK; #1;
        tests_run++;
        if (cpu_rdata !== 32'h0) begin
            tests_failed++; $display("FAIL systick_restart: got %h expected 0", cpu_rdata);
        end
        @(negedge clk); #1;
        tests_run++;
        if (cpu_rdata !== 32'h1) begin
            tests_failed++; $display("FAIL systick_restart1: got %h expected 1", cpu_rdata);
        end
        collect_frames(30, nframes);
        tests_run++;
        if (nframes !== 0) begin
            tests_failed++; $display("FAIL fifo_discard: got %0d frames expected 0", nframes);
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_led_digits();
        test_timer();
        test_uart_frame();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
